// File: rtl/fp_rf_pkg.sv
// rtl/fp_rf_pkg.sv - shared types and constants for the FP register file with scoreboard
package fp_rf_pkg;

    localparam int FP_RF_AW_DEFAULT = 5;
    localparam int FP_RF_FLEN       = 64;

    // Write-back source; FPU is encoded first because it wins collisions
    typedef enum logic {
        WB_FPU = 1'b0,
        WB_LSU = 1'b1
    } fp_wb_src_e;

    typedef struct packed {
        logic                        valid;
        logic [FP_RF_AW_DEFAULT-1:0] rd;
        logic [FP_RF_FLEN-1:0]       data;
    } fp_wb_req_t;

endpackage

// File: rtl/fp_rf_scoreboard.sv
// rtl/fp_rf_scoreboard.sv - busy bits, issue handshake, flush and sticky write-back conflict flag
// Optional: FP_RF_BYPASS_EN lets an issue see a register cleared in the same cycle as free.
module fp_rf_scoreboard
    import fp_rf_pkg::*;
#(
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_issue_valid,
    input  logic [AW-1:0]    i_issue_rd,
    input  logic             i_fpu_valid,
    input  logic [AW-1:0]    i_fpu_rd,
    input  logic             i_lsu_valid,
    input  logic [AW-1:0]    i_lsu_rd,
    input  logic             i_flush,
    output logic             o_issue_ready,
    output logic [NREGS-1:0] o_busy,
    output logic             o_conflict
);

    logic [NREGS-1:0] r_busy;
    logic             r_conflict;
    logic [NREGS-1:0] w_clr;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_busy_eff;
    logic             w_issue_ready;

    always_comb begin
        w_clr = '0;
        if (i_fpu_valid) w_clr[i_fpu_rd] = 1'b1;
        if (i_lsu_valid) w_clr[i_lsu_rd] = 1'b1;
    end

`ifdef FP_RF_BYPASS_EN
    assign w_busy_eff = r_busy & ~w_clr;
`else
    assign w_busy_eff = r_busy;
`endif

    assign w_issue_ready = i_issue_valid & ~w_busy_eff[i_issue_rd] & ~i_flush;

    always_comb begin
        w_set = '0;
        if (w_issue_ready) w_set[i_issue_rd] = 1'b1;
    end

    // Set is ORed after the clear so a new producer keeps ownership
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_busy     <= '0;
            r_conflict <= 1'b0;
        end else begin
            r_busy <= i_flush ? '0 : ((r_busy & ~w_clr) | w_set);
            if (i_fpu_valid && i_lsu_valid && (i_fpu_rd == i_lsu_rd)) begin
                r_conflict <= 1'b1;
            end
        end
    end

    assign o_issue_ready = w_issue_ready;
    assign o_busy        = r_busy;
    assign o_conflict    = r_conflict;

endmodule

// File: rtl/fp_regfile_sb.sv
// rtl/fp_regfile_sb.sv - parametrised FP register file, two write-back ports, integrated scoreboard
// Optional: FP_RF_BYPASS_EN forwards same-cycle write-back data and busy clears to the read ports.
module fp_regfile_sb
    import fp_rf_pkg::*;
#(
    parameter int unsigned FLEN  = 32,
    parameter int unsigned NREGS = 1 << FP_RF_AW_DEFAULT,
    parameter int unsigned NREAD = 3,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NREAD*AW-1:0]   rd_addr_i,
    output logic [NREAD*FLEN-1:0] rd_data_o,
    output logic [NREAD-1:0]      rd_busy_o,
    input  logic                  issue_valid_i,
    input  logic [AW-1:0]         issue_rd_i,
    output logic                  issue_ready_o,
    input  logic                  fpu_wb_valid_i,
    input  logic [AW-1:0]         fpu_wb_rd_i,
    input  logic [FLEN-1:0]       fpu_wb_data_i,
    input  logic                  lsu_wb_valid_i,
    input  logic [AW-1:0]         lsu_wb_rd_i,
    input  logic [FLEN-1:0]       lsu_wb_data_i,
    input  logic                  flush_i,
    output logic [NREGS-1:0]      busy_o,
    output logic                  wb_conflict_o
);

    logic [FLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] w_wr_en;
    fp_wb_src_e       w_wr_src [NREGS];
    logic [NREGS-1:0] w_busy;

    fp_rf_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .i_issue_valid (issue_valid_i),
        .i_issue_rd    (issue_rd_i),
        .i_fpu_valid   (fpu_wb_valid_i),
        .i_fpu_rd      (fpu_wb_rd_i),
        .i_lsu_valid   (lsu_wb_valid_i),
        .i_lsu_rd      (lsu_wb_rd_i),
        .i_flush       (flush_i),
        .o_issue_ready (issue_ready_o),
        .o_busy        (w_busy),
        .o_conflict    (wb_conflict_o)
    );

    assign busy_o = w_busy;

    // Per-register write select; FPU is checked first so it wins a collision
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            w_wr_en[i]  = 1'b0;
            w_wr_src[i] = WB_FPU;
            if (fpu_wb_valid_i && (fpu_wb_rd_i == AW'(i))) begin
                w_wr_en[i]  = 1'b1;
                w_wr_src[i] = WB_FPU;
            end else if (lsu_wb_valid_i && (lsu_wb_rd_i == AW'(i))) begin
                w_wr_en[i]  = 1'b1;
                w_wr_src[i] = WB_LSU;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_wr_en[i]) begin
                    r_regs[i] <= (w_wr_src[i] == WB_FPU) ? fpu_wb_data_i : lsu_wb_data_i;
                end
            end
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic [FLEN-1:0] w_data;

        assign w_addr = rd_addr_i[k*AW +: AW];

`ifdef FP_RF_BYPASS_EN
        always_comb begin
            w_data = r_regs[w_addr];
            if (fpu_wb_valid_i && (fpu_wb_rd_i == w_addr)) begin
                w_data = fpu_wb_data_i;
            end else if (lsu_wb_valid_i && (lsu_wb_rd_i == w_addr)) begin
                w_data = lsu_wb_data_i;
            end
        end
        // Any write-back to the register clears its busy bit this cycle
        assign rd_busy_o[k] = w_busy[w_addr] & ~w_wr_en[w_addr];
`else
        assign w_data       = r_regs[w_addr];
        assign rd_busy_o[k] = w_busy[w_addr];
`endif

        assign rd_data_o[k*FLEN +: FLEN] = w_data;
    end

endmodule

// File: tb/tb_fp_regfile_sb.sv
// tb/tb_fp_regfile_sb.sv - directed scoreboard bench for fp_regfile_sb (default and 64-bit configs)
module tb_fp_regfile_sb;

`ifdef FP_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: FLEN=32, NREGS=32, NREAD=3
    logic          rst_a_n;
    logic [14:0]   rd_addr_a;
    logic [95:0]   rd_data_a;
    logic [2:0]    rd_busy_a;
    logic          issue_valid_a;
    logic [4:0]    issue_rd_a;
    logic          issue_ready_a;
    logic          fpu_valid_a;
    logic [4:0]    fpu_rd_a;
    logic [31:0]   fpu_data_a;
    logic          lsu_valid_a;
    logic [4:0]    lsu_rd_a;
    logic [31:0]   lsu_data_a;
    logic          flush_a;
    logic [31:0]   busy_a;
    logic          conflict_a;

    // Instance B: FLEN=64, NREGS=16, NREAD=2
    logic          rst_b_n;
    logic [7:0]    rd_addr_b;
    logic [127:0]  rd_data_b;
    logic [1:0]    rd_busy_b;
    logic          issue_valid_b;
    logic [3:0]    issue_rd_b;
    logic          issue_ready_b;
    logic          fpu_valid_b;
    logic [3:0]    fpu_rd_b;
    logic [63:0]   fpu_data_b;
    logic          lsu_valid_b;
    logic [3:0]    lsu_rd_b;
    logic [63:0]   lsu_data_b;
    logic          flush_b;
    logic [15:0]   busy_b;
    logic          conflict_b;

    fp_regfile_sb u_dut_a (
        .clk_i          (clk),
        .rst_ni         (rst_a_n),
        .rd_addr_i      (rd_addr_a),
        .rd_data_o      (rd_data_a),
        .rd_busy_o      (rd_busy_a),
        .issue_valid_i  (issue_valid_a),
        .issue_rd_i     (issue_rd_a),
        .issue_ready_o  (issue_ready_a),
        .fpu_wb_valid_i (fpu_valid_a),
        .fpu_wb_rd_i    (fpu_rd_a),
        .fpu_wb_data_i  (fpu_data_a),
        .lsu_wb_valid_i (lsu_valid_a),
        .lsu_wb_rd_i    (lsu_rd_a),
        .lsu_wb_data_i  (lsu_data_a),
        .flush_i        (flush_a),
        .busy_o         (busy_a),
        .wb_conflict_o  (conflict_a)
    );

    fp_regfile_sb #(
        .FLEN  (64),
        .NREGS (16),
        .NREAD (2)
    ) u_dut_b (
        .clk_i          (clk),
        .rst_ni         (rst_b_n),
        .rd_addr_i      (rd_addr_b),
        .rd_data_o      (rd_data_b),
        .rd_busy_o      (rd_busy_b),
        .issue_valid_i  (issue_valid_b),
        .issue_rd_i     (issue_rd_b),
        .issue_ready_o  (issue_ready_b),
        .fpu_wb_valid_i (fpu_valid_b),
        .fpu_wb_rd_i    (fpu_rd_b),
        .fpu_wb_data_i  (fpu_data_b),
        .lsu_wb_valid_i (lsu_valid_b),
        .lsu_wb_rd_i    (lsu_rd_b),
        .lsu_wb_data_i  (lsu_data_b),
        .flush_i        (flush_b),
        .busy_o         (busy_b),
        .wb_conflict_o  (conflict_b)
    );

    logic [63:0] exp_q [$];
    string       tag_q [$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_busy;

    task automatic push(input string t, input logic [63:0] e);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic pop_check(input logic [63:0] obs);
        logic [63:0] e;
        string       t;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_underflow observed=%h expected=<none>", obs);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        vectors++;
        assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        rd_addr_a = {5'd31, 5'd5, 5'd0}; rd_addr_b = '0;
        issue_valid_a = 1'b1; issue_rd_a = '0;
        fpu_valid_a = 1'b0; fpu_rd_a = '0; fpu_data_a = '0;
        lsu_valid_a = 1'b0; lsu_rd_a = '0; lsu_data_a = '0;
        flush_a = 1'b0;
        issue_valid_b = 1'b0; issue_rd_b = '0;
        fpu_valid_b = 1'b0; fpu_rd_b = '0; fpu_data_b = '0;
        lsu_valid_b = 1'b0; lsu_rd_b = '0; lsu_data_b = '0;
        flush_b = 1'b0;

        // Reset state
        #12;
        push("reset_rd_data", 64'h0);       pop_check(64'(rd_data_a[31:0]));
        push("reset_rd_data5", 64'h0);      pop_check(64'(rd_data_a[63:32]));
        push("reset_rd_data31", 64'h0);     pop_check(64'(rd_data_a[95:64]));
        push("reset_busy", 64'h0);          pop_check(64'(busy_a));
        push("reset_conflict", 64'h0);      pop_check(64'(conflict_a));
        push("reset_issue_ready", 64'h1);   pop_check(64'(issue_ready_a));
        issue_valid_a = 1'b0;
        @(negedge clk);
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        tick();

        // Issue rd=3 twice, then FPU write-back
        issue_valid_a = 1'b1; issue_rd_a = 5'd3;
        #1;
        push("issue3_ready", 64'h1);        pop_check(64'(issue_ready_a));
        tick();
        push("issue3_again_stall", 64'h0);  pop_check(64'(issue_ready_a));
        push("busy3_set", 64'h8);           pop_check(64'(busy_a));
        issue_valid_a = 1'b0;
        fpu_valid_a = 1'b1; fpu_rd_a = 5'd3; fpu_data_a = 32'h3F80_0000;
        rd_addr_a = {5'd31, 5'd5, 5'd3};
        #1;
        push("wb3_same_cycle_data", BYP ? 64'h3F80_0000 : 64'h0);
        pop_check(64'(rd_data_a[31:0]));
        push("wb3_same_cycle_rd_busy", BYP ? 64'h0 : 64'h1);
        pop_check(64'(rd_busy_a[0]));
        push("busy3_cleared", 64'h0);
        push("reg3_data", 64'h3F80_0000);
        tick();
        fpu_valid_a = 1'b0;
        #1;
        pop_check(64'(busy_a));
        pop_check(64'(rd_data_a[31:0]));

        // Same-register collision on both write ports
        fpu_valid_a = 1'b1; fpu_rd_a = 5'd7; fpu_data_a = 32'h4000_0000;
        lsu_valid_a = 1'b1; lsu_rd_a = 5'd7; lsu_data_a = 32'hC000_0000;
        rd_addr_a = {5'd31, 5'd7, 5'd3};
        #1;
        push("collide_bypass_data", BYP ? 64'h4000_0000 : 64'h0);
        pop_check(64'(rd_data_a[63:32]));
        push("collide_reg7", 64'h4000_0000);
        push("collide_conflict", 64'h1);
        tick();
        fpu_valid_a = 1'b0; lsu_valid_a = 1'b0;
        #1;
        pop_check(64'(rd_data_a[63:32]));
        pop_check(64'(conflict_a));
        tick(); tick(); tick();
        push("conflict_sticky", 64'h1);     pop_check(64'(conflict_a));

        // Issue rd=4 then reissue in the write-back cycle
        issue_valid_a = 1'b1; issue_rd_a = 5'd4;
        #1;
        push("issue4_ready", 64'h1);        pop_check(64'(issue_ready_a));
        tick();
        push("busy4_set", 64'h1);           pop_check(64'(busy_a[4]));
        fpu_valid_a = 1'b1; fpu_rd_a = 5'd4; fpu_data_a = 32'h1111_1111;
        #1;
        push("reissue4_ready", BYP ? 64'h1 : 64'h0);
        pop_check(64'(issue_ready_a));
        push("reissue4_busy", BYP ? 64'h1 : 64'h0);
        tick();
        fpu_valid_a = 1'b0; issue_valid_a = 1'b0;
        #1;
        pop_check(64'(busy_a[4]));

        // Busy 1, 2, 9 then flush with an LSU write-back
        exp_busy = BYP ? 32'h10 : 32'h0;
        issue_valid_a = 1'b1;
        issue_rd_a = 5'd1; tick();
        issue_rd_a = 5'd2; tick();
        issue_rd_a = 5'd9; tick();
        exp_busy = exp_busy | 32'h206;
        push("busy_1_2_9", 64'(exp_busy));  pop_check(64'(busy_a));
        issue_rd_a = 5'd10; flush_a = 1'b1;
        lsu_valid_a = 1'b1; lsu_rd_a = 5'd2; lsu_data_a = 32'h1234_5678;
        rd_addr_a = {5'd2, 5'd7, 5'd3};
        #1;
        push("flush_issue_ready", 64'h0);   pop_check(64'(issue_ready_a));
        push("flush_busy", 64'h0);
        push("flush_reg2", 64'h1234_5678);
        tick();
        flush_a = 1'b0; lsu_valid_a = 1'b0; issue_valid_a = 1'b0;
        #1;
        pop_check(64'(busy_a));
        pop_check(64'(rd_data_a[95:64]));

        // Instance B: 64-bit write to reg 15 without a prior issue
        fpu_valid_b = 1'b1; fpu_rd_b = 4'd15; fpu_data_b = 64'hFFFF_FFFF_3F80_0000;
        rd_addr_b = {4'd15, 4'd5};
        push("b_reg15", 64'hFFFF_FFFF_3F80_0000);
        push("b_busy_after_wb", 64'h0);
        tick();
        fpu_valid_b = 1'b0;
        #1;
        pop_check(rd_data_b[127:64]);
        pop_check(64'(busy_b));

        // Asynchronous reset mid-transaction
        issue_valid_b = 1'b1; issue_rd_b = 4'd5;
        tick();
        issue_valid_b = 1'b0;
        push("b_busy5", 64'h20);            pop_check(64'(busy_b));
        lsu_valid_b = 1'b1; lsu_rd_b = 4'd5; lsu_data_b = 64'hDEAD_BEEF_0000_0001;
        #2;
        rst_b_n = 1'b0;
        #1;
        push("b_async_reg15", 64'h0);       pop_check(rd_data_b[127:64]);
        push("b_async_busy", 64'h0);        pop_check(64'(busy_b));
        lsu_valid_b = 1'b0;
        tick();
        push("b_held_reg5", 64'h0);         pop_check(rd_data_b[63:0]);

        if (exp_q.size() != 0) begin
            miscompares++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
